opb_cmd_master: RTL

OPB bus master that turns a simple valid/ready command stream into single-beat OPB read or write transfers. It is the initiator end of the same OPB slave interface our software-register and snapshot blocks implement. It lets fabric logic, such as a config sequencer or self-test engine, poke and peek slave registers without the PPC. It has one command in flight at a time, with bounded retry and timeout handling, and returns read data plus a status code.

---
 rtl/opb_cmd_master.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/opb_cmd_master.sv
// opb_cmd_master: turns a valid/ready command stream into single-beat OPB
// read/write transfers. One command in flight, bounded retry, timeout
// detection, and a response carrying read data plus a status code.
// All outputs are registered. Bus outputs stay zero whenever M_select is low.
module opb_cmd_master #(
   parameter int    C_TIMEOUT_CYCLES = 16,
   parameter int    C_MAX_RETRY      = 3,
   parameter string C_FAMILY         = "virtex6"
) (
   input  logic        OPB_Clk,
   input  logic        OPB_Rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rnw,
   input  logic [0:31] cmd_addr,
   input  logic [0:3]  cmd_be,
   input  logic [0:31] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [0:31] rsp_rdata,
   output logic [1:0]  rsp_status,
   output logic        M_request,
   input  logic        OPB_MGrant,
   output logic        M_select,
   output logic        M_RNW,
   output logic [0:31] M_ABus,
   output logic [0:3]  M_BE,
   output logic [0:31] M_DBus,
   output logic        M_seqAddr,
   output logic        M_busLock,
   input  logic [0:31] OPB_DBus,
   input  logic        OPB_xferAck,
   input  logic        OPB_errAck,
   input  logic        OPB_retry,
   input  logic        OPB_toutSup
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam logic [1:0] STS_OK       = 2'b00;
   localparam logic [1:0] STS_ERR      = 2'b01;
   localparam logic [1:0] STS_TIMEOUT  = 2'b10;
   localparam logic [1:0] STS_RETRY_EX = 2'b11;

   // Counter limits; the timeout fires on the cycle the count would reach C_TIMEOUT_CYCLES.
   localparam logic [7:0] MAX_RETRY_C = 8'(C_MAX_RETRY);
   localparam logic [7:0] TOUT_LAST_C = 8'(C_TIMEOUT_CYCLES - 1);

   state_t      state_r, state_nx_s;
   logic        rnw_r;
   logic [0:31] addr_r;
   logic [0:3]  be_r;
   logic [0:31] wdata_r;
   logic [7:0]  retry_cnt_r, retry_nx_s;
   logic [7:0]  tout_cnt_r, tout_nx_s;
   logic        load_cmd_s;
   logic        xfer_nx_s;
   logic [0:31] rdata_nx_s;
   logic [1:0]  status_nx_s;

   logic        cmd_ready_r;
   logic        m_request_r;
   logic        m_select_r;
   logic        m_rnw_r;
   logic [0:31] m_abus_r;
   logic [0:3]  m_be_r;
   logic [0:31] m_dbus_r;
   logic        rsp_valid_r;
   logic [0:31] rsp_rdata_r;
   logic [1:0]  rsp_status_r;

   // Next-state, counter and response decode; xferAck > errAck > retry > timeout.
   always_comb begin
      state_nx_s  = state_r;
      retry_nx_s  = retry_cnt_r;
      tout_nx_s   = tout_cnt_r;
      rdata_nx_s  = rsp_rdata_r;
      status_nx_s = rsp_status_r;
      load_cmd_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_r) begin
               state_nx_s = ST_REQ;
               retry_nx_s = 8'd0;
               load_cmd_s = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (OPB_MGrant) begin
               state_nx_s = ST_XFER;
               tout_nx_s  = 8'd0;
            end else begin
               state_nx_s = ST_REQ;
            end
         end
         ST_XFER: begin
            if (OPB_xferAck) begin
               rdata_nx_s  = rnw_r ? OPB_DBus : 32'd0;
               status_nx_s = STS_OK;
               state_nx_s  = ST_RESP;
            end else if (OPB_errAck) begin
               rdata_nx_s  = 32'd0;
               status_nx_s = STS_ERR;
               state_nx_s  = ST_RESP;
            end else if (OPB_retry) begin
               if (retry_cnt_r < MAX_RETRY_C) begin
                  retry_nx_s = retry_cnt_r + 8'd1;
                  state_nx_s = ST_REQ;
               end else begin
                  rdata_nx_s  = 32'd0;
                  status_nx_s = STS_RETRY_EX;
                  state_nx_s  = ST_RESP;
               end
            end else if (!OPB_toutSup) begin
               if (tout_cnt_r == TOUT_LAST_C) begin
                  rdata_nx_s  = 32'd0;
                  status_nx_s = STS_TIMEOUT;
                  state_nx_s  = ST_RESP;
               end else begin
                  tout_nx_s = tout_cnt_r + 8'd1;
               end
            end else begin
               tout_nx_s = tout_cnt_r;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_nx_s  = ST_IDLE;
               rdata_nx_s  = 32'd0;
               status_nx_s = STS_OK;
            end else begin
               state_nx_s = ST_RESP;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   assign xfer_nx_s = (state_nx_s == ST_XFER);

   // State register, counters and latched command.
   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         state_r     <= ST_IDLE;
         retry_cnt_r <= 8'd0;
         tout_cnt_r  <= 8'd0;
         rnw_r       <= 1'b0;
         addr_r      <= 32'd0;
         be_r        <= 4'd0;
         wdata_r     <= 32'd0;
      end else begin
         state_r     <= state_nx_s;
         retry_cnt_r <= retry_nx_s;
         tout_cnt_r  <= tout_nx_s;
         if (load_cmd_s) begin
            rnw_r   <= cmd_rnw;
            addr_r  <= cmd_addr;
            be_r    <= cmd_be;
            wdata_r <= cmd_wdata;
         end else begin
            rnw_r   <= rnw_r;
            addr_r  <= addr_r;
            be_r    <= be_r;
            wdata_r <= wdata_r;
         end
      end
   end

   // Registered outputs derived from the next state; bus lines zero unless selected.
   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         cmd_ready_r  <= 1'b0;
         m_request_r  <= 1'b0;
         m_select_r   <= 1'b0;
         m_rnw_r      <= 1'b0;
         m_abus_r     <= 32'd0;
         m_be_r       <= 4'd0;
         m_dbus_r     <= 32'd0;
         rsp_valid_r  <= 1'b0;
         rsp_rdata_r  <= 32'd0;
         rsp_status_r <= 2'b00;
      end else begin
         cmd_ready_r  <= (state_nx_s == ST_IDLE);
         m_request_r  <= (state_nx_s == ST_REQ);
         m_select_r   <= xfer_nx_s;
         m_rnw_r      <= xfer_nx_s ? rnw_r : 1'b0;
         m_abus_r     <= xfer_nx_s ? addr_r : 32'd0;
         m_be_r       <= xfer_nx_s ? be_r : 4'd0;
         m_dbus_r     <= (xfer_nx_s && !rnw_r) ? wdata_r : 32'd0;
         rsp_valid_r  <= (state_nx_s == ST_RESP);
         rsp_rdata_r  <= rdata_nx_s;
         rsp_status_r <= status_nx_s;
      end
   end

   assign cmd_ready  = cmd_ready_r;
   assign M_request  = m_request_r;
   assign M_select   = m_select_r;
   assign M_RNW      = m_rnw_r;
   assign M_ABus     = m_abus_r;
   assign M_BE       = m_be_r;
   assign M_DBus     = m_dbus_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_rdata  = rsp_rdata_r;
   assign rsp_status = rsp_status_r;
   // Single-beat, non-locked transfers only.
   assign M_seqAddr  = 1'b0;
   assign M_busLock  = 1'b0;

endmodule
